// File: rtl/bg_stats_sequencer.sv
`default_nettype none
// ============================================================================
// bg_stats_sequencer: walks every pixel of every training frame, doing a
// read-modify-write of its statistics record through one memory port.
// Optional read watchdog: BG_SEQ_TIMEOUT_EN.   Revision: 1.0
// ============================================================================
module bg_stats_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HEIGHT      = 4,
  parameter int NUM_FRAMES  = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 336,
  parameter int STRIDE      = 1,
  parameter logic [ADDR_WIDTH-1:0] SUM_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] RESULT_BASE = 32'h0010_0000,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_FRAMES):0]     frame_idx,
  output logic [$clog2(WIDTH*HEIGHT):0]   pixel_idx,
  output logic                            mem_cmd_valid,
  input  logic                            mem_cmd_ready,
  output logic                            mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]           mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            upd_valid,
  output logic [DATA_WIDTH-1:0]           upd_data,
  output logic                            upd_final,
  input  logic                            res_valid,
  input  logic [DATA_WIDTH-1:0]           res_data,
  output logic                            timeout_err
);

  localparam int NUM_PIX = WIDTH * HEIGHT;
  localparam int FW      = $clog2(NUM_FRAMES) + 1;
  localparam int PW      = $clog2(NUM_PIX) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    UPDATE  = 3'd3,
    WR_CMD  = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t state;

`ifdef BG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_err = 1'b0;
`endif

  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [PW-1:0] idx);
    return base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(STRIDE);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_idx     <= '0;
      pixel_idx     <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_wdata     <= '0;
      upd_valid     <= 1'b0;
      upd_data      <= '0;
      upd_final     <= 1'b0;
`ifdef BG_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped
          if (start && !done) begin
            frame_idx <= '0;
            pixel_idx <= '0;
            busy      <= 1'b1;
            upd_valid <= 1'b1;
            upd_data  <= '0;
            upd_final <= (NUM_FRAMES == 1);
            state     <= UPDATE;
          end
        end
        RD_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= RD_WAIT;
`ifdef BG_SEQ_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (mem_rdata_valid) begin
            upd_data  <= mem_rdata;
            upd_valid <= 1'b1;
            state     <= UPDATE;
          end
`ifdef BG_SEQ_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            upd_data    <= '0;
            upd_valid   <= 1'b1;
            state       <= UPDATE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        UPDATE: begin
          if (res_valid) begin
            mem_wdata     <= res_data;
            upd_valid     <= 1'b0;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b1;
            mem_cmd_addr  <= pix_addr(upd_final ? RESULT_BASE : SUM_BASE, pixel_idx);
            state         <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            mem_cmd_write <= 1'b0;
            state         <= NEXT;
          end
        end
        NEXT: begin
          if (pixel_idx != PW'(NUM_PIX - 1)) begin
            pixel_idx <= pixel_idx + PW'(1);
            if (frame_idx == '0) begin
              upd_valid <= 1'b1;
              upd_data  <= '0;
              state     <= UPDATE;
            end else begin
              mem_cmd_valid <= 1'b1;
              mem_cmd_write <= 1'b0;
              mem_cmd_addr  <= pix_addr(SUM_BASE, pixel_idx + PW'(1));
              state         <= RD_CMD;
            end
          end else if (frame_idx != FW'(NUM_FRAMES - 1)) begin
            pixel_idx     <= '0;
            frame_idx     <= frame_idx + FW'(1);
            upd_final     <= ((frame_idx + FW'(1)) == FW'(NUM_FRAMES - 1));
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b0;
            mem_cmd_addr  <= pix_addr(SUM_BASE, '0);
            state         <= RD_CMD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bg_stats_sequencer.sv
`default_nettype none
// Bench for bg_stats_sequencer: reactive memory and datapath models driven cycle
// by cycle, checked against a per-pixel running-sum reference.
module tb_bg_stats_sequencer;

  localparam int W = 2, H = 2, NF = 2, NPIX = W * H;
  localparam int AW = 32, DW = 336, STRIDE = 1, TIMEOUT = 8;
  localparam int FW = $clog2(NF) + 1, PW = $clog2(NPIX) + 1, CW = 512;
  localparam logic [AW-1:0] SB = 32'h0000_0000;
  localparam logic [AW-1:0] RB = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [FW-1:0] frame_idx;
  logic [PW-1:0] pixel_idx;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, upd_data, res_data;
  logic mem_rdata_valid, upd_valid, upd_final, res_valid, timeout_err;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] exp_sum [NPIX];

  always #5 clk = ~clk;

  bg_stats_sequencer #(
    .WIDTH(W), .HEIGHT(H), .NUM_FRAMES(NF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .STRIDE(STRIDE), .SUM_BASE(SB), .RESULT_BASE(RB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .frame_idx(frame_idx), .pixel_idx(pixel_idx),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_final(upd_final),
    .res_valid(res_valid), .res_data(res_data), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, mem_cmd_valid, mem_cmd_write, upd_valid, upd_final,
                         timeout_err, frame_idx, pixel_idx}, '0);
    chk({tag, "_addr"}, mem_cmd_addr, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_upd_data"}, upd_data, '0);
  endtask

  // One model build. Entered and left on a falling edge.
  task automatic run_build(input int maxd, input bit noise, input bit stall_wr,
                           input int abort_px, input int hold_px, output int busy_cyc);
    int mf = 0, mp = 0, cyc = 0, rdy_dly = 0, resp_dly = 0, res_dly = 0, hold_wait = 0;
    bit cmd_seen = 0, rd_pend = 0, rd_hold = 0, rd_done = 0, timed_out = 0;
    bit upd_seen = 0, res_sent = 0, stalled = 0, finished = 0, do_abort = 0, prev_valid = 0;
    logic [AW-1:0] rd_addr = '0, prev_addr = '0;
    logic prev_write = 1'b0;
    logic [DW-1:0] prev_wdata = '0, cur_exp = '0, inc;
    busy_cyc = 0;
    start = 1'b1;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
      res_valid = 1'b0; res_data = '0;
      if (do_abort) begin
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort_reset");
        rst = 1'b0;
        return;
      end
      if (cyc == 1) begin
        chk("start_busy", busy, 1);
        chk("start_upd_valid", upd_valid, 1);
        chk("start_idx", {frame_idx, pixel_idx}, 0);
        chk("start_no_read", mem_cmd_valid, 0);
      end
      if (busy) busy_cyc++;
      if (done) begin
        chk("done_busy_low", busy, 0);
        chk("done_all_pixels", mf, NF);
        finished = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_done_ignored", {busy, done, upd_valid}, 0);
        break;
      end
      if (prev_valid)
        chk("cmd_held", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata},
            {1'b1, prev_write, prev_addr, prev_wdata});
      // memory read response for an earlier accepted read
      if (rd_pend && !rd_hold) begin
        if (resp_dly > 0) resp_dly--;
        else begin
          mem_rdata_valid = 1'b1;
          mem_rdata = mem[rd_addr];
          rd_pend = 0;
        end
      end
      if (rd_hold && !upd_valid) hold_wait++;
      // datapath model
      if (upd_valid && !res_sent) begin
        if (!upd_seen) begin
          upd_seen = 1;
          if (rd_hold) begin
            chk("timeout_latency", hold_wait, TIMEOUT);
            chk("timeout_err_set", timeout_err, 1);
            rd_hold = 0; rd_pend = 0; timed_out = 1;
          end
          cur_exp = (mf == 0 || timed_out) ? '0 : exp_sum[mp];
          chk("upd_data", upd_data, cur_exp);
          chk("upd_final", upd_final, (mf == NF - 1));
          chk("upd_idx", {frame_idx, pixel_idx}, {FW'(mf), PW'(mp)});
          res_dly = $urandom_range(0, maxd);
        end
        if (res_dly > 0) res_dly--;
        else begin
          inc = (maxd == 0) ? DW'(1) : DW'($urandom_range(1, 1000));
          res_valid = 1'b1;
          res_data = cur_exp + inc;
          exp_sum[mp] = cur_exp + inc;
          res_sent = 1;
        end
        if (noise) begin
          mem_rdata_valid = 1'b1;
          mem_rdata = DW'(8'hAA);
        end
      end else if (noise && !upd_valid && $urandom_range(0, 2) == 0) begin
        res_valid = 1'b1;
        res_data = DW'({$urandom, $urandom});
      end
      if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      // memory command side
      if (mem_cmd_valid) begin
        if (!cmd_seen) begin
          cmd_seen = 1;
          if (stall_wr && mem_cmd_write && !stalled) begin rdy_dly = 10; stalled = 1; end
          else rdy_dly = $urandom_range(0, maxd);
        end
        if (rdy_dly > 0) begin
          rdy_dly--;
          prev_valid = 1; prev_write = mem_cmd_write;
          prev_addr = mem_cmd_addr; prev_wdata = mem_wdata;
        end else begin
          mem_cmd_ready = 1'b1; cmd_seen = 0; prev_valid = 0;
          if (!mem_cmd_write) begin
            chk("rd_expected", {(mf > 0 && mf < NF), rd_done, rd_pend}, 3'b100);
            chk("rd_addr", mem_cmd_addr, SB + AW'(mp * STRIDE));
            chk("rd_idx", {frame_idx, pixel_idx}, {FW'(mf), PW'(mp)});
            rd_done = 1; rd_pend = 1; rd_addr = mem_cmd_addr;
            resp_dly = $urandom_range(0, maxd);
            if (mf == 1 && mp == abort_px) do_abort = 1;
            if (mf == 1 && mp == hold_px) begin rd_hold = 1; hold_wait = 0; end
          end else begin
            chk("wr_order", {res_sent, (rd_done || mf == 0)}, 2'b11);
            chk("wr_addr", mem_cmd_addr, ((mf == NF - 1) ? RB : SB) + AW'(mp * STRIDE));
            chk("wr_data", mem_wdata, exp_sum[mp]);
            mem[mem_cmd_addr] = mem_wdata;
            mp++;
            if (mp == NPIX) begin mp = 0; mf++; end
            upd_seen = 0; res_sent = 0; rd_done = 0; timed_out = 0;
          end
        end
      end else begin
        prev_valid = 0;
        cmd_seen = 0;
      end
    end
    chk("build_completed", finished, 1);
  endtask

  initial begin
    int bc;
    rst = 1'b1; start = 1'b0; mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0;
    mem_rdata = '0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, mem_cmd_valid, upd_valid}, 0);

    // zero-wait memory, datapath adds 1, spurious strobes injected
    run_build(0, 1'b1, 1'b0, -1, -1, bc);
    chk("cycle_count", bc, NPIX * (3 + 5 * (NF - 1)));
    for (int i = 0; i < NPIX; i++) begin
      chk("sum_region", mem[SB + AW'(i)], 1);
      chk("result_region", mem[RB + AW'(i)], 2);
    end

    // random latencies with one 10-cycle write stall
    run_build(3, 1'b1, 1'b1, -1, -1, bc);
    // reset while waiting for the read of frame 1, pixel 2, then a clean restart
    run_build(2, 1'b0, 1'b0, 2, -1, bc);
    run_build(1, 1'b1, 1'b0, -1, -1, bc);
`ifdef BG_SEQ_TIMEOUT_EN
    run_build(1, 1'b0, 1'b0, -1, 1, bc);
    chk("timeout_sticky", timeout_err, 1);
`else
    chk("timeout_tied_low", timeout_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
